// File: rtl/period_meter_if.sv
// Result channel of period_meter: measured period plus its qualifiers on a valid/ready handshake.
// A result transfers on a clock edge where period_valid and period_ready are both high;
// period and overflow are held stable for as long as period_valid is high.
interface period_meter_if #(
  parameter int WIDTH = 18
);
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_ready;
  logic             overflow;
  logic             overrun;

  modport master (
    output period,
    output period_valid,
    output overflow,
    output overrun,
    input  period_ready
  );

  modport slave (
    input  period,
    input  period_valid,
    input  overflow,
    input  overrun,
    output period_ready
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: counts clock cycles between accepted rising edges of an asynchronous input.
// Optional macro PERIOD_METER_AVG_EN emits the floor average of each group of 4 periods.
module period_meter #(
  parameter int WIDTH      = 18,
  parameter int MIN_PERIOD = 4
) (
  input  logic           CLK_50_MHz,
  input  logic           reset,
  input  logic           sig_in,
  period_meter_if.master res,
  output logic [0:0]     dbg_state_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam logic [WIDTH-1:0] SAT   = '1;
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic             meas_done, meas_tmo;
  logic             emit;
  logic [WIDTH-1:0] emit_period;
  logic             emit_ovf;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;

  assign rise    = sync2_q & ~sync3_q;
  assign cnt_inc = cnt_q + WIDTH'(1);

  // cnt holds the cycles elapsed since the last accepted edge, so cnt+1 is the period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    meas_done = 1'b0;
    meas_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) state_d = ST_MEASURE;
      end
      default: begin
        if (rise && (cnt_inc >= MIN_P)) begin
          meas_done = 1'b1;
          cnt_d     = '0;
        end else if (cnt_inc == SAT) begin
          meas_tmo = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  logic [WIDTH+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       grp_q, grp_d;

  assign acc_sum = acc_q + {2'b00, cnt_inc};

  always_comb begin
    acc_d       = acc_q;
    grp_d       = grp_q;
    emit        = 1'b0;
    emit_period = SAT;
    emit_ovf    = 1'b0;
    if (meas_tmo) begin
      acc_d    = '0;
      grp_d    = '0;
      emit     = 1'b1;
      emit_ovf = 1'b1;
    end else if (meas_done) begin
      if (grp_q == 2'd3) begin
        emit        = 1'b1;
        emit_period = acc_sum[WIDTH+1:2];
        acc_d       = '0;
        grp_d       = '0;
      end else begin
        acc_d = acc_sum;
        grp_d = grp_q + 2'd1;
      end
    end
  end

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      grp_q <= '0;
    end else begin
      acc_q <= acc_d;
      grp_q <= grp_d;
    end
  end
`else
  assign emit        = meas_done | meas_tmo;
  assign emit_period = meas_tmo ? SAT : cnt_inc;
  assign emit_ovf    = meas_tmo;
`endif

  // A result arriving while the previous one is still pending is dropped, never stalled.
  always_comb begin
    period_d  = period_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && res.period_ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (emit) begin
      if (!valid_q || res.period_ready) begin
        period_d = emit_period;
        ovf_d    = emit_ovf;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= sig_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign res.period       = period_q;
  assign res.period_valid = valid_q;
  assign res.overflow     = ovf_q;
  assign res.overrun      = overrun_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: scenario tasks drive sig_in and push expected results;
// a negedge monitor pops and compares every accepted transfer.
module tb_period_meter;
  localparam int WIDTH      = 12;
  localparam int MIN_PERIOD = 4;
  localparam logic [WIDTH-1:0] SAT = '1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic [0:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int pops         = 0;
  logic ovr_seen   = 1'b0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] mon_got, mon_exp;

  period_meter_if #(.WIDTH(WIDTH)) res ();

  period_meter #(.WIDTH(WIDTH), .MIN_PERIOD(MIN_PERIOD)) dut (
    .CLK_50_MHz  (clk),
    .reset       (rst),
    .sig_in      (sig),
    .res         (res),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && res.period_valid && res.period_ready) begin
      tests_run++;
      pops++;
      mon_got = {res.overflow, res.period};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL result_unexpected: got ovf=%0b period=%0d, required no result",
                 res.overflow, res.period);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          tests_failed++;
          $display("FAIL result: got ovf=%0b period=%0d, required ovf=%0b period=%0d",
                   mon_got[WIDTH], mon_got[WIDTH-1:0], mon_exp[WIDTH], mon_exp[WIDTH-1:0]);
        end
      end
    end
    if (!rst && res.overrun) ovr_seen = 1'b1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sig = 1'b0;
    wait_n(3);
    exp_q.delete();
    ovr_seen = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d results still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res.period_ready = 1'b0;
    wait_n(2);
    tests_run += 5;
    if (res.period !== '0) begin tests_failed++; $display("FAIL reset_period: got %0d, required 0", res.period); end
    if (res.period_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", res.period_valid); end
    if (res.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b, required 0", res.overflow); end
    if (res.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b, required 0", res.overrun); end
    if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL reset_state: got %b, required 0", dbg_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_steady();
    int p0;
    do_reset();
    res.period_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      sig = 1'b1;
      if (i > 0) exp_q.push_back({1'b0, WIDTH'(1000)});
      wait_n(500);
      sig = 1'b0;
      wait_n(500);
    end
    drain("steady_drain", 20);
    tests_run += 2;
    if (pops - p0 !== 9) begin tests_failed++; $display("FAIL steady_count: got %0d results, required 9", pops - p0); end
    if (ovr_seen !== 1'b0) begin tests_failed++; $display("FAIL steady_overrun: got %b, required 0", ovr_seen); end
  endtask

  // continues from test_steady: the input stays low after the last accepted edge
  task automatic test_timeout();
    int p0;
    exp_q.push_back({1'b1, SAT});
    drain("timeout_result", 4000);
    tests_run++;
    if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL timeout_idle: got state %b, required 0", dbg_state); end
    p0 = pops;
    sig = 1'b1;
    wait_n(300);
    sig = 1'b0;
    wait_n(300);
    tests_run += 2;
    if (pops !== p0) begin tests_failed++; $display("FAIL rearm_no_result: got %0d results, required 0", pops - p0); end
    if (dbg_state !== 1'b1) begin tests_failed++; $display("FAIL rearm_state: got %b, required 1", dbg_state); end
    sig = 1'b1;
    exp_q.push_back({1'b0, WIDTH'(600)});
    wait_n(10);
    sig = 1'b0;
    drain("rearm_result", 20);
  endtask

  task automatic test_glitch();
    do_reset();
    res.period_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sig = 1'b1;
      if (i > 0) exp_q.push_back({1'b0, WIDTH'(1000)});
      tick();
      sig = 1'b0;
      wait_n(2);
      sig = 1'b1;
      tick();
      sig = 1'b0;
      wait_n(996);
    end
    drain("glitch_drain", 20);
  endtask

  task automatic test_backpressure();
    do_reset();
    res.period_ready = 1'b0;
    sig = 1'b1;
    wait_n(250);
    sig = 1'b0;
    wait_n(250);
    sig = 1'b1;
    exp_q.push_back({1'b0, WIDTH'(500)});
    wait_n(5);
    tests_run += 4;
    if (res.period_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %b, required 1", res.period_valid); end
    if (res.period !== WIDTH'(500)) begin tests_failed++; $display("FAIL bp_period: got %0d, required 500", res.period); end
    if (res.overflow !== 1'b0) begin tests_failed++; $display("FAIL bp_overflow: got %b, required 0", res.overflow); end
    if (res.overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_overrun_early: got %b, required 0", res.overrun); end
    wait_n(245);
    sig = 1'b0;
    wait_n(250);
    sig = 1'b1;
    wait_n(5);
    tests_run += 3;
    if (res.overrun !== 1'b1) begin tests_failed++; $display("FAIL bp_overrun: got %b, required 1", res.overrun); end
    if (res.period !== WIDTH'(500)) begin tests_failed++; $display("FAIL bp_held: got %0d, required 500", res.period); end
    if (res.period_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_held: got %b, required 1", res.period_valid); end
    wait_n(195);
    sig = 1'b0;
    wait_n(5);
    res.period_ready = 1'b1;
    tick();
    tests_run += 2;
    if (res.overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_overrun_clear: got %b, required 0", res.overrun); end
    if (res.period_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_clear: got %b, required 0", res.period_valid); end
    drain("bp_drain", 5);
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    res.period_ready = 1'b1;
    sig = 1'b1;
    wait_n(100);
    sig = 1'b0;
    wait_n(900);
    sig = 1'b1;
    exp_q.push_back({1'b0, WIDTH'(1000)});
    wait_n(10);
    res.period_ready = 1'b0;
    wait_n(90);
    sig = 1'b0;
    wait_n(900);
    sig = 1'b1;
    exp_q.push_back({1'b0, WIDTH'(1000)});
    wait_n(100);
    sig = 1'b0;
    wait_n(200);
    tests_run++;
    if (res.period_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_pending: got %b, required 1", res.period_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests_run += 4;
    if (res.period !== '0) begin tests_failed++; $display("FAIL rm_period: got %0d, required 0", res.period); end
    if (res.period_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid: got %b, required 0", res.period_valid); end
    if (res.overflow !== 1'b0) begin tests_failed++; $display("FAIL rm_overflow: got %b, required 0", res.overflow); end
    if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL rm_state: got %b, required 0", dbg_state); end
    exp_q.pop_back();
    drain("rm_first", 1);
    wait_n(5);
    rst = 1'b0;
    res.period_ready = 1'b1;
    p0 = pops;
    wait_n(50);
    sig = 1'b1;
    wait_n(100);
    sig = 1'b0;
    wait_n(900);
    tests_run++;
    if (pops !== p0) begin tests_failed++; $display("FAIL rm_arm_only: got %0d results, required 0", pops - p0); end
    sig = 1'b1;
    exp_q.push_back({1'b0, WIDTH'(1000)});
    wait_n(100);
    sig = 1'b0;
    drain("rm_after", 20);
  endtask

  task automatic test_back_to_back();
    do_reset();
    res.period_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sig = 1'b1;
      if (i > 0) exp_q.push_back({1'b0, WIDTH'(MIN_PERIOD)});
      wait_n(2);
      sig = 1'b0;
      wait_n(2);
    end
    drain("b2b_min", 20);
    tests_run++;
    if (ovr_seen !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun: got %b, required 0", ovr_seen); end
    // edges 3 cycles apart: every other edge is a glitch, so results read 6
    do_reset();
    for (int i = 0; i < 12; i++) begin
      sig = 1'b1;
      if (i >= 2 && (i % 2) == 0) exp_q.push_back({1'b0, WIDTH'(6)});
      tick();
      sig = 1'b0;
      wait_n(2);
    end
    drain("b2b_below_min", 20);
  endtask

  task automatic test_avg();
    int per[4];
    int p0;
    per[0] = 1000; per[1] = 1001; per[2] = 1002; per[3] = 1003;
    do_reset();
    res.period_ready = 1'b1;
    p0 = pops;
    sig = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_n(100);
      sig = 1'b0;
      wait_n(per[k] - 100);
      if (k == 3) exp_q.push_back({1'b0, WIDTH'(1001)});
      sig = 1'b1;
    end
    wait_n(100);
    sig = 1'b0;
    drain("avg_result", 20);
    tests_run++;
    if (pops - p0 !== 1) begin tests_failed++; $display("FAIL avg_count: got %0d results, required 1", pops - p0); end
  endtask

  initial begin
    res.period_ready = 1'b0;
    test_reset();
`ifdef PERIOD_METER_AVG_EN
    test_avg();
`else
    test_steady();
    test_timeout();
    test_glitch();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
